// File: rtl/mem_fifo_buf.sv
// mem_fifo_buf: single-clock FIFO buffer with occupancy count, full/empty,
// programmable almost-full/almost-empty flags and registered read data.
// Optional sticky overflow/underflow flags are built when the macro
// MEM_FIFO_BUF_ERR_FLAGS_EN is defined; otherwise ovf/udf are tied low.
module mem_fifo_buf #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADD_WIDTH  = 6,
   parameter int unsigned AFULL_LVL  = 56,
   parameter int unsigned AEMPTY_LVL = 8
) (
   input  logic                  rclk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  wen,
   input  logic                  ren,
   input  logic                  err_clr,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_vld,
   output logic                  full,
   output logic                  empty,
   output logic                  afull,
   output logic                  aempty,
   output logic [ADD_WIDTH:0]    count,
   output logic                  ovf,
   output logic                  udf
);

   localparam int unsigned DEPTH = 2 ** ADD_WIDTH;
   localparam logic [ADD_WIDTH:0] DEPTH_C  = (ADD_WIDTH + 1)'(DEPTH);
   localparam logic [ADD_WIDTH:0] AFULL_C  = (ADD_WIDTH + 1)'(AFULL_LVL);
   localparam logic [ADD_WIDTH:0] AEMPTY_C = (ADD_WIDTH + 1)'(AEMPTY_LVL);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADD_WIDTH:0]    wptr;
   logic [ADD_WIDTH:0]    rptr;
   logic                  wr_acc;
   logic                  rd_acc;

   // Occupancy and flags decode straight from the registered pointers; the
   // extra wrap bit disambiguates full from empty when the addresses match.
   assign count  = wptr - rptr;
   assign full   = (count == DEPTH_C);
   assign empty  = (wptr == rptr);
   assign afull  = (count >= AFULL_C);
   assign aempty = (count <= AEMPTY_C);

   // No bypass: acceptance looks only at the pre-edge flags.
   assign wr_acc = wen && !full;
   assign rd_acc = ren && !empty;

   // Storage array, intentionally not reset.
   always_ff @(posedge rclk) begin
      if (wr_acc) begin
         mem[wptr[ADD_WIDTH-1:0]] <= din;
      end
   end

   // Pointer advance; rollover of the wrap bit is natural.
   always_ff @(posedge rclk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr_acc) begin
            wptr <= wptr + 1'b1;
         end
         if (rd_acc) begin
            rptr <= rptr + 1'b1;
         end
      end
   end

   // Registered read port; dout holds its value between accepted reads.
   always_ff @(posedge rclk or posedge rst) begin
      if (rst) begin
         dout     <= '0;
         dout_vld <= 1'b0;
      end else begin
         dout_vld <= rd_acc;
         if (rd_acc) begin
            dout <= mem[rptr[ADD_WIDTH-1:0]];
         end
      end
   end

`ifdef MEM_FIFO_BUF_ERR_FLAGS_EN
   // Sticky error flags; a set event in the same cycle beats err_clr.
   always_ff @(posedge rclk or posedge rst) begin
      if (rst) begin
         ovf <= 1'b0;
         udf <= 1'b0;
      end else begin
         if (wen && full) begin
            ovf <= 1'b1;
         end else if (err_clr) begin
            ovf <= 1'b0;
         end
         if (ren && empty) begin
            udf <= 1'b1;
         end else if (err_clr) begin
            udf <= 1'b0;
         end
      end
   end
`else
   logic unused_err_clr;

   assign unused_err_clr = err_clr;
   assign ovf            = 1'b0;
   assign udf            = 1'b0;
`endif

endmodule

// File: tb/tb_mem_fifo_buf.sv
// tb_mem_fifo_buf: randomized scoreboard bench for mem_fifo_buf. Stimulus
// tasks update a queue-based reference model and push expected read data;
// a negedge monitor compares every output against the model.
module tb_mem_fifo_buf;

   localparam int DW    = 32;
   localparam int AW    = 6;
   localparam int DEPTH = 64;
   localparam int AF    = 56;
   localparam int AE    = 8;

   logic          rclk;
   logic          rst;
   logic [DW-1:0] din;
   logic          wen;
   logic          ren;
   logic          err_clr;
   logic [DW-1:0] dout;
   logic          dout_vld;
   logic          full;
   logic          empty;
   logic          afull;
   logic          aempty;
   logic [AW:0]   count;
   logic          ovf;
   logic          udf;

   mem_fifo_buf #(
      .DATA_WIDTH (DW),
      .ADD_WIDTH  (AW),
      .AFULL_LVL  (AF),
      .AEMPTY_LVL (AE)
   ) dut (
      .rclk     (rclk),
      .rst      (rst),
      .din      (din),
      .wen      (wen),
      .ren      (ren),
      .err_clr  (err_clr),
      .dout     (dout),
      .dout_vld (dout_vld),
      .full     (full),
      .empty    (empty),
      .afull    (afull),
      .aempty   (aempty),
      .count    (count),
      .ovf      (ovf),
      .udf      (udf)
   );

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   // Reference model state
   logic [DW-1:0] mq[$];
   logic [DW-1:0] exp_q[$];
   bit            exp_vld;
   logic [DW-1:0] last_dout;
   bit            m_ovf;
   bit            m_udf;
   bit            run;
   logic [DW-1:0] e;

   int errors;
   int checks;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      exp_q.delete();
      exp_vld   = 1'b0;
      last_dout = '0;
      m_ovf     = 1'b0;
      m_udf     = 1'b0;
   endtask

   // One clock of stimulus: drive at negedge, update model at posedge.
   task automatic cycle(input bit w, input bit r, input logic [DW-1:0] d, input bit c);
      int sz;
      wen     = w;
      ren     = r;
      din     = d;
      err_clr = c;
      @(posedge rclk);
      sz = mq.size();
`ifdef MEM_FIFO_BUF_ERR_FLAGS_EN
      if (w && sz == DEPTH) m_ovf = 1'b1;
      else if (c) m_ovf = 1'b0;
      if (r && sz == 0) m_udf = 1'b1;
      else if (c) m_udf = 1'b0;
`endif
      exp_vld = r && (sz > 0);
      if (exp_vld) exp_q.push_back(mq.pop_front());
      if (w && sz < DEPTH) mq.push_back(d);
      @(negedge rclk);
      wen     = 1'b0;
      ren     = 1'b0;
      err_clr = 1'b0;
   endtask

   // Monitor: compare outputs against the model away from the active edge.
   always @(negedge rclk) begin
      if (run && !rst) begin
         chk("count", DW'(count), DW'(mq.size()));
         chk("full", DW'(full), DW'(mq.size() == DEPTH));
         chk("empty", DW'(empty), DW'(mq.size() == 0));
         chk("afull", DW'(afull), DW'(mq.size() >= AF));
         chk("aempty", DW'(aempty), DW'(mq.size() <= AE));
         chk("ovf", DW'(ovf), DW'(m_ovf));
         chk("udf", DW'(udf), DW'(m_udf));
         chk("dout_vld", DW'(dout_vld), DW'(exp_vld));
         if (dout_vld) begin
            if (exp_q.size() == 0) begin
               chk("dout_unexpected", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("dout", dout, e);
               last_dout = e;
            end
         end else begin
            chk("dout_hold", dout, last_dout);
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_count"}, DW'(count), 0);
      chk({tag, "_empty"}, DW'(empty), 1);
      chk({tag, "_full"}, DW'(full), 0);
      chk({tag, "_afull"}, DW'(afull), 0);
      chk({tag, "_aempty"}, DW'(aempty), 1);
      chk({tag, "_dout"}, dout, 0);
      chk({tag, "_dout_vld"}, DW'(dout_vld), 0);
      chk({tag, "_ovf"}, DW'(ovf), 0);
      chk({tag, "_udf"}, DW'(udf), 0);
   endtask

   initial begin
      errors  = 0;
      checks  = 0;
      run     = 1'b0;
      rst     = 1'b0;
      wen     = 1'b0;
      ren     = 1'b0;
      err_clr = 1'b0;
      din     = '0;
      model_reset();
      #1 rst = 1'b1;
      #1 check_reset_outputs("reset");
      @(negedge rclk);
      @(negedge rclk);
      rst = 1'b0;
      run = 1'b1;
      cycle(0, 0, 0, 0);

      // Fill with 0..63, then drain in order at full rate
      for (int i = 0; i < DEPTH; i++) cycle(1, 0, DW'(i), 0);
      for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, 0);
      cycle(0, 0, 0, 0);

      // Write while full with a simultaneous read: write dropped
      for (int i = 0; i < DEPTH; i++) cycle(1, 0, $urandom, 0);
      cycle(1, 1, 32'hDEAD, 0);
      cycle(0, 0, 0, 1);
      for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, 0);

      // Read while empty with a simultaneous write: read rejected
      cycle(1, 1, 32'h55, 0);
      cycle(0, 1, 0, 0);
      cycle(0, 0, 0, 1);

      // Wrap: random traffic holding occupancy between 30 and 40
      for (int i = 0; i < 35; i++) cycle(1, 0, $urandom, 0);
      for (int i = 0; i < 400; i++) begin
         bit w;
         bit r;
         w = 1'($urandom_range(0, 1));
         r = 1'($urandom_range(0, 1));
         if (mq.size() >= 40) begin
            w = 1'b0;
            r = 1'b1;
         end else if (mq.size() <= 30) begin
            w = 1'b1;
            r = 1'b0;
         end
         cycle(w, r, $urandom, 1'($urandom_range(0, 7) == 0));
      end
      while (mq.size() > 0) cycle(0, 1, 0, 0);

      // Asynchronous reset mid-burst with count=20 and dout_vld high
      for (int i = 0; i < 21; i++) cycle(1, 0, $urandom | 32'h1, 0);
      cycle(1, 1, $urandom | 32'h1, 0);
      cycle(0, 1, 0, 0);
      #2 rst = 1'b1;
      #1 check_reset_outputs("async_rst");
      model_reset();
      @(posedge rclk);
      @(negedge rclk);
      rst = 1'b0;
      cycle(1, 0, 32'hA5, 0);
      cycle(0, 1, 0, 0);
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 0);

      chk("scoreboard_drained", DW'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
